// File: rtl/router_pkg.sv
// Shared flit-type encodings and arbiter state type for the torus router output ports.
package router_pkg;

    localparam int FLIT_SIZE_DEF = 128;
    localparam int FLIT_TYPE_W   = 2;

    localparam logic [FLIT_TYPE_W-1:0] FLIT_TYPE_BODY   = 2'b00;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_TYPE_HEAD   = 2'b01;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_TYPE_TAIL   = 2'b10;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_TYPE_SINGLE = 2'b11;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // True for flits that open a packet (HEAD or SINGLE).
    function automatic logic is_head_type(input logic [FLIT_TYPE_W-1:0] t);
        return (t == FLIT_TYPE_HEAD) || (t == FLIT_TYPE_SINGLE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: requests above ptr win first, otherwise lowest index.
module rr_arbiter #(
    parameter int NUM_REQ = 7,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pick;

    always_comb begin
        upper_mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            upper_mask[i] = (IW'(i) > ptr);
        end
        masked = req & upper_mask;
        pick   = (|masked) ? masked : req;

        grant = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick[i] && (grant == '0)) begin
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port wormhole switch allocator with credit gating and registered output.
// Optional statistics counters enabled by defining OUT_ARB_STATS_EN.
module output_port_arbiter
    import router_pkg::*;
#(
    parameter int FLIT_SIZE    = FLIT_SIZE_DEF,
    parameter int NUM_REQ      = 7,
    parameter int CREDIT_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*FLIT_SIZE-1:0] req_flit,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [FLIT_SIZE-1:0]         out_flit,
    output logic                         out_valid,
    input  logic                         credit_return,
    output logic                         proto_err,
    output logic                         credit_err
`ifdef OUT_ARB_STATS_EN
    ,
    output logic [31:0]                  flit_cnt,
    output logic [31:0]                  stall_cnt
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CREDIT_DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDIT_DEPTH);

    arb_state_t      state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   credits;

    logic [FLIT_SIZE-1:0]   flits [NUM_REQ];
    logic [FLIT_TYPE_W-1:0] ftype [NUM_REQ];
    logic [NUM_REQ-1:0]     head_mask;
    logic [NUM_REQ-1:0]     body_mask;
    logic [NUM_REQ-1:0]     arb_req;
    logic [NUM_REQ-1:0]     arb_grant;
    logic [IW-1:0]          arb_idx;
    logic                   arb_any;
    logic [IW-1:0]          drain_idx;
    logic                   has_credit;

    logic [IW-1:0]          sel_idx;
    logic [FLIT_SIZE-1:0]   sel_flit;
    logic [FLIT_TYPE_W-1:0] sel_type;
    logic                   fwd;
    logic                   drain;

    always_comb begin
        head_mask = '0;
        body_mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            flits[i]     = req_flit[i*FLIT_SIZE +: FLIT_SIZE];
            ftype[i]     = flits[i][FLIT_SIZE-1 -: FLIT_TYPE_W];
            head_mask[i] = req_valid[i] && is_head_type(ftype[i]);
            body_mask[i] = req_valid[i] && !is_head_type(ftype[i]);
        end
        has_credit = (credits != '0);
        arb_req    = has_credit ? head_mask : '0;

        drain_idx = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (body_mask[i-1]) begin
                drain_idx = IW'(i - 1);
            end
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Orphan body/tail flits are only drained when no head can be granted.
    always_comb begin
        req_ready = '0;
        sel_idx   = '0;
        fwd       = 1'b0;
        drain     = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    sel_idx   = arb_idx;
                    fwd       = 1'b1;
                end else if (|body_mask) begin
                    req_ready[drain_idx] = 1'b1;
                    sel_idx              = drain_idx;
                    drain                = 1'b1;
                end
            end
            ARB_LOCKED: begin
                if (req_valid[owner] && has_credit) begin
                    req_ready[owner] = 1'b1;
                    sel_idx          = owner;
                    fwd              = 1'b1;
                end
            end
            default: ;
        endcase
        sel_flit = flits[sel_idx];
        sel_type = ftype[sel_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            rr_ptr     <= IW'(NUM_REQ - 1);
            credits    <= CREDIT_FULL;
            out_flit   <= '0;
            out_valid  <= 1'b0;
            proto_err  <= 1'b0;
            credit_err <= 1'b0;
        end else begin
            out_valid  <= fwd;
            proto_err  <= drain;
            credit_err <= credit_return && !fwd && (credits == CREDIT_FULL);
            if (fwd) begin
                out_flit <= sel_flit;
            end

            if (fwd && !credit_return) begin
                credits <= credits - CW'(1);
            end else if (credit_return && !fwd && (credits != CREDIT_FULL)) begin
                credits <= credits + CW'(1);
            end

            case (state)
                ARB_IDLE: begin
                    if (fwd) begin
                        rr_ptr <= sel_idx;
                        if (sel_type == FLIT_TYPE_HEAD) begin
                            state <= ARB_LOCKED;
                            owner <= sel_idx;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (fwd && (sel_type == FLIT_TYPE_TAIL)) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef OUT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (fwd) begin
                flit_cnt <= flit_cnt + 32'd1;
            end
            if ((|req_valid) && !has_credit && !(|req_ready)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed table-driven bench for output_port_arbiter (CREDIT_DEPTH=4).
module tb_output_port_arbiter;

    localparam int FS = 128;
    localparam int NR = 7;
    localparam int CD = 4;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] T = 2'b10;
    localparam logic [1:0] S = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*FS-1:0] req_flit;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [FS-1:0]    out_flit;
    logic             out_valid;
    logic             credit_return;
    logic             proto_err;
    logic             credit_err;
`ifdef OUT_ARB_STATS_EN
    logic [31:0]      flit_cnt;
    logic [31:0]      stall_cnt;
`endif

    output_port_arbiter #(
        .FLIT_SIZE    (FS),
        .NUM_REQ      (NR),
        .CREDIT_DEPTH (CD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_flit      (req_flit),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .out_flit      (out_flit),
        .out_valid     (out_valid),
        .credit_return (credit_return),
        .proto_err     (proto_err),
        .credit_err    (credit_err)
`ifdef OUT_ARB_STATS_EN
        ,
        .flit_cnt      (flit_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  valid;
        logic [13:0] typ;
        logic        cr;
        logic [6:0]  ready;
        logic        ov;
        logic        pe;
        logic        ce;
    } vec_t;

    localparam int NV = 29;
    vec_t tbl [NV];

    int total = 0;
    int bad   = 0;
    logic [FS-1:0] last_flit;

    task automatic chk(input string name, input logic [FS-1:0] act, input logic [FS-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [FS-1:0] mkf(input int src, input int v, input logic [1:0] t);
        logic [FS-1:0] f;
        f = '0;
        f[FS-1 -: 2] = t;
        f[31:16] = 16'(v);
        f[15:0]  = 16'(src);
        return f;
    endfunction

    function automatic vec_t mk(input logic [6:0] val, input int ia, input logic [1:0] ta,
                                input int ib, input logic [1:0] tb, input logic cr,
                                input logic [6:0] rdy, input logic ov, input logic pe,
                                input logic ce);
        vec_t e;
        e.valid = val;
        e.typ = '0;
        e.typ[2*ia +: 2] = ta;
        e.typ[2*ib +: 2] = tb;
        e.cr = cr;
        e.ready = rdy;
        e.ov = ov;
        e.pe = pe;
        e.ce = ce;
        return e;
    endfunction

    task automatic drive(input logic [6:0] val, input logic [13:0] typ, input logic cr, input int v);
        for (int i = 0; i < NR; i++) begin
            req_flit[i*FS +: FS] = mkf(i, v, typ[2*i +: 2]);
        end
        req_valid     = val;
        credit_return = cr;
    endtask

    initial begin
        // Two singles, then a packet with a competing head, credit recycling.
        tbl[0]  = mk(7'b0001001, 0, S, 3, S, 0, 7'b0000001, 1, 0, 0);
        tbl[1]  = mk(7'b0001000, 3, S, 3, S, 0, 7'b0001000, 1, 0, 0);
        tbl[2]  = mk(7'b0000000, 0, B, 0, B, 1, 7'b0000000, 0, 0, 0);
        tbl[3]  = mk(7'b0000000, 0, B, 0, B, 1, 7'b0000000, 0, 0, 0);
        tbl[4]  = mk(7'b0000100, 2, H, 2, H, 0, 7'b0000100, 1, 0, 0);
        tbl[5]  = mk(7'b0100100, 2, B, 5, H, 0, 7'b0000100, 1, 0, 0);
        tbl[6]  = mk(7'b0100100, 2, T, 5, H, 0, 7'b0000100, 1, 0, 0);
        tbl[7]  = mk(7'b0100000, 5, H, 5, H, 1, 7'b0100000, 1, 0, 0);
        tbl[8]  = mk(7'b0100000, 5, T, 5, T, 1, 7'b0100000, 1, 0, 0);
        tbl[9]  = mk(7'b0000000, 0, B, 0, B, 1, 7'b0000000, 0, 0, 0);
        tbl[10] = mk(7'b0000000, 0, B, 0, B, 1, 7'b0000000, 0, 0, 0);
        tbl[11] = mk(7'b0000000, 0, B, 0, B, 1, 7'b0000000, 0, 0, 0);
        // Orphan drain, credit overflow, head beats drain.
        tbl[12] = mk(7'b0010000, 4, B, 4, B, 0, 7'b0010000, 0, 1, 0);
        tbl[13] = mk(7'b0000000, 0, B, 0, B, 1, 7'b0000000, 0, 0, 1);
        tbl[14] = mk(7'b0000000, 0, B, 0, B, 0, 7'b0000000, 0, 0, 0);
        tbl[15] = mk(7'b1000010, 1, B, 6, S, 0, 7'b1000000, 1, 0, 0);
        tbl[16] = mk(7'b0000010, 1, B, 1, B, 1, 7'b0000010, 0, 1, 0);
        // Credit exhaustion while streaming from req1.
        tbl[17] = mk(7'b0000010, 1, H, 1, H, 0, 7'b0000010, 1, 0, 0);
        tbl[18] = mk(7'b0000010, 1, B, 1, B, 0, 7'b0000010, 1, 0, 0);
        tbl[19] = mk(7'b0000010, 1, B, 1, B, 0, 7'b0000010, 1, 0, 0);
        tbl[20] = mk(7'b0000010, 1, B, 1, B, 0, 7'b0000010, 1, 0, 0);
        tbl[21] = mk(7'b0000010, 1, B, 1, B, 0, 7'b0000000, 0, 0, 0);
        tbl[22] = mk(7'b0000011, 1, B, 0, H, 0, 7'b0000000, 0, 0, 0);
        tbl[23] = mk(7'b0000010, 1, B, 1, B, 1, 7'b0000000, 0, 0, 0);
        tbl[24] = mk(7'b0000010, 1, B, 1, B, 0, 7'b0000010, 1, 0, 0);
        tbl[25] = mk(7'b0000010, 1, T, 1, T, 1, 7'b0000000, 0, 0, 0);
        tbl[26] = mk(7'b0000010, 1, T, 1, T, 0, 7'b0000010, 1, 0, 0);
        tbl[27] = mk(7'b0001000, 3, H, 3, H, 1, 7'b0000000, 0, 0, 0);
        tbl[28] = mk(7'b0001000, 3, H, 3, H, 0, 7'b0001000, 1, 0, 0);

        rst = 1'b1;
        drive(7'b0, 14'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        last_flit = '0;
        chk("reset out_valid", FS'(out_valid), FS'(0));
        chk("reset out_flit", out_flit, '0);
        chk("reset proto_err", FS'(proto_err), FS'(0));
        chk("reset credit_err", FS'(credit_err), FS'(0));
`ifdef OUT_ARB_STATS_EN
        chk("reset flit_cnt", FS'(flit_cnt), FS'(0));
        chk("reset stall_cnt", FS'(stall_cnt), FS'(0));
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            if (v != 0) @(negedge clk);
            drive(tbl[v].valid, tbl[v].typ, tbl[v].cr, v);
            #1;
            chk($sformatf("v%0d ready", v), FS'(req_ready), FS'(tbl[v].ready));
            @(posedge clk);
            #1;
            if (tbl[v].ov) begin
                for (int i = 0; i < NR; i++) begin
                    if (tbl[v].ready[i]) last_flit = mkf(i, v, tbl[v].typ[2*i +: 2]);
                end
            end
            chk($sformatf("v%0d out_valid", v), FS'(out_valid), FS'(tbl[v].ov));
            chk($sformatf("v%0d proto_err", v), FS'(proto_err), FS'(tbl[v].pe));
            chk($sformatf("v%0d credit_err", v), FS'(credit_err), FS'(tbl[v].ce));
            chk($sformatf("v%0d out_flit", v), out_flit, last_flit);
        end

`ifdef OUT_ARB_STATS_EN
        chk("flit_cnt after table", FS'(flit_cnt), FS'(15));
        chk("stall_cnt after table", FS'(stall_cnt), FS'(5));
`endif

        // Reset while req3 owns the port with zero credits left.
        @(negedge clk);
        rst = 1'b1;
        drive(7'b0001001, {2'b00, 2'b00, 2'b00, B, 2'b00, 2'b00, H}, 1'b0, 99);
        @(posedge clk);
        #1;
        last_flit = '0;
        chk("midreset out_valid", FS'(out_valid), FS'(0));
        chk("midreset out_flit", out_flit, '0);
        chk("midreset proto_err", FS'(proto_err), FS'(0));
`ifdef OUT_ARB_STATS_EN
        chk("midreset flit_cnt", FS'(flit_cnt), FS'(0));
        chk("midreset stall_cnt", FS'(stall_cnt), FS'(0));
`endif
        for (int k = 0; k < 5; k++) begin
            logic [1:0] t0;
            @(negedge clk);
            rst = 1'b0;
            t0 = (k == 0) ? H : B;
            drive(7'b0001001, {2'b00, 2'b00, 2'b00, B, 2'b00, 2'b00, t0}, 1'b0, 100 + k);
            #1;
            chk($sformatf("post%0d ready", k), FS'(req_ready), FS'((k < CD) ? 7'b0000001 : 7'b0000000));
            @(posedge clk);
            #1;
            if (k < CD) last_flit = mkf(0, 100 + k, t0);
            chk($sformatf("post%0d out_valid", k), FS'(out_valid), FS'((k < CD) ? 1 : 0));
            chk($sformatf("post%0d out_flit", k), out_flit, last_flit);
            chk($sformatf("post%0d proto_err", k), FS'(proto_err), FS'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
